mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-controller-side signals of the memory port arbiter.
// The arbiter uses the slave view; a requester/controller model uses the master view.
interface mem_port_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  wea;
  logic [3:0]  be0, be1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [2:0]  sc0, sc1;
  logic        lock;
  logic [1:0]  ack;
  logic [1:0]  err;
  logic [31:0] rdata;
  logic [3:0]  mem_en;
  logic        mem_wea;
  logic        mem_rea;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [2:0]  storecntrl;
  logic [31:0] mem_dout;
  logic        mem_hold;
  logic [1:0]  owner;

  modport slave (
    input  req, wea, be0, be1, addr0, addr1, wdata0, wdata1, sc0, sc1, lock,
    input  mem_dout, mem_hold,
    output ack, err, rdata, mem_en, mem_wea, mem_rea, mem_addr, mem_din, storecntrl, owner
  );

  modport master (
    output req, wea, be0, be1, addr0, addr1, wdata0, wdata1, sc0, sc1, lock,
    output mem_dout, mem_hold,
    input  ack, err, rdata, mem_en, mem_wea, mem_rea, mem_addr, mem_din, storecntrl, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the memory controller data port between the core (0) and the
// UART loader (1), with a programming-mode lock and a hold-stall timeout abort.
module mem_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               Rst_n,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [15:0] TcntLast = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [1:0]  owner_q, owner_d;
  logic        abort_q, abort_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        cmdWea_q, cmdWea_d;
  logic [3:0]  cmdBe_q, cmdBe_d;
  logic [31:0] cmdAddr_q, cmdAddr_d;
  logic [31:0] cmdWdata_q, cmdWdata_d;
  logic [2:0]  cmdSc_q, cmdSc_d;

  logic [1:0]  eligible;
  logic        winner;
  logic        inBusy, inDone;

  // In programming mode only the loader may compete; ties go to whoever was not served last.
  assign eligible = bus.lock ? {bus.req[1], 1'b0} : bus.req;
  assign winner   = (eligible == 2'b11) ? ~last_q : eligible[1];

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      owner_q    <= '0;
      abort_q    <= 1'b0;
      tcnt_q     <= '0;
      rdata_q    <= '0;
      cmdWea_q   <= 1'b0;
      cmdBe_q    <= '0;
      cmdAddr_q  <= '0;
      cmdWdata_q <= '0;
      cmdSc_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      abort_q    <= abort_d;
      tcnt_q     <= tcnt_d;
      rdata_q    <= rdata_d;
      cmdWea_q   <= cmdWea_d;
      cmdBe_q    <= cmdBe_d;
      cmdAddr_q  <= cmdAddr_d;
      cmdWdata_q <= cmdWdata_d;
      cmdSc_q    <= cmdSc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    abort_d    = abort_q;
    tcnt_d     = tcnt_q;
    rdata_d    = rdata_q;
    cmdWea_d   = cmdWea_q;
    cmdBe_d    = cmdBe_q;
    cmdAddr_d  = cmdAddr_q;
    cmdWdata_d = cmdWdata_q;
    cmdSc_d    = cmdSc_q;

    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d    = BUSY;
          last_d     = winner;
          owner_d    = winner ? 2'b10 : 2'b01;
          abort_d    = 1'b0;
          tcnt_d     = '0;
          cmdWea_d   = winner ? bus.wea[1] : bus.wea[0];
          cmdBe_d    = winner ? bus.be1    : bus.be0;
          cmdAddr_d  = winner ? bus.addr1  : bus.addr0;
          cmdWdata_d = winner ? bus.wdata1 : bus.wdata0;
          cmdSc_d    = winner ? bus.sc1    : bus.sc0;
        end
      end
      BUSY: begin
        if (!bus.mem_hold) begin
          state_d = DONE;
          if (!cmdWea_q) rdata_d = bus.mem_dout;
        end else if (tcnt_q == TcntLast) begin
          state_d = DONE;
          abort_d = 1'b1;
        end else if (tcnt_q != 16'hFFFF) begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        owner_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign inBusy = (state_q == BUSY);
  assign inDone = (state_q == DONE);

  assign bus.mem_en     = inBusy ? cmdBe_q    : '0;
  assign bus.mem_wea    = inBusy & cmdWea_q;
  assign bus.mem_rea    = inBusy & ~cmdWea_q;
  assign bus.mem_addr   = inBusy ? cmdAddr_q  : '0;
  assign bus.mem_din    = inBusy ? cmdWdata_q : '0;
  assign bus.storecntrl = inBusy ? cmdSc_q    : '0;
  assign bus.ack        = (inDone && !abort_q) ? owner_q : '0;
  assign bus.err        = (inDone &&  abort_q) ? owner_q : '0;
  assign bus.rdata      = rdata_q;
  assign bus.owner      = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios push expected transactions,
// a negedge monitor checks every BUSY cycle and every ack/err pulse against the queue head.
module tb_mem_port_arbiter;

  typedef struct {
    logic [1:0]  grant;
    logic        isErr;
    logic        wea;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  sc;
    logic [31:0] rdata;
    int          busyCycles;
  } exp_t;

  logic clk = 1'b0;
  logic Rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   busyCnt = 0;
  exp_t expQ[$];
  exp_t head;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT(6)) dut (
    .clk   (clk),
    .Rst_n (Rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] reqV, input logic lockV, input logic holdV,
                               input logic [31:0] doutV);
    bus.req      = reqV;
    bus.lock     = lockV;
    bus.mem_hold = holdV;
    bus.mem_dout = doutV;
  endtask

  task automatic setCmd(input int idx, input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] s);
    if (idx == 0) begin
      bus.wea[0] = w; bus.be0 = b; bus.addr0 = a; bus.wdata0 = d; bus.sc0 = s;
    end else begin
      bus.wea[1] = w; bus.be1 = b; bus.addr1 = a; bus.wdata1 = d; bus.sc1 = s;
    end
  endtask

  function automatic exp_t mkExp(input logic [1:0] g, input logic e, input logic w, input logic [3:0] b,
                                 input logic [31:0] a, input logic [31:0] d, input logic [2:0] s,
                                 input logic [31:0] r, input int n);
    exp_t x;
    x.grant = g; x.isErr = e; x.wea = w; x.be = b; x.addr = a;
    x.wdata = d; x.sc = s; x.rdata = r; x.busyCycles = n;
    return x;
  endfunction

  task automatic waitCompletions(input int n, input int budget);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (|(bus.ack | bus.err)) seen++;
    end
    checkOutput("completions within budget", 96'(seen), 96'(n));
  endtask

  // Monitor: every BUSY cycle must match the oldest outstanding transaction; each pulse retires it.
  always @(negedge clk) begin
    if (Rst_n) begin
      if (bus.mem_wea | bus.mem_rea) begin
        checkOutput("pending expectation at busy", 96'(expQ.size() != 0), 96'(1));
        if (expQ.size() != 0) begin
          head = expQ[0];
          checkOutput("strobes", {bus.mem_en, bus.mem_wea, bus.mem_rea, bus.storecntrl},
                      {head.be, head.wea, ~head.wea, head.sc});
          checkOutput("mem_addr", bus.mem_addr, head.addr);
          checkOutput("mem_din", bus.mem_din, head.wdata);
          checkOutput("owner in busy", bus.owner, head.grant);
          busyCnt++;
        end
      end else begin
        checkOutput("idle mem outputs", {bus.mem_en, bus.storecntrl, bus.mem_addr, bus.mem_din}, '0);
      end
      if (|(bus.ack | bus.err)) begin
        checkOutput("pending expectation at completion", 96'(expQ.size() != 0), 96'(1));
        if (expQ.size() != 0) begin
          head = expQ.pop_front();
          checkOutput("ack", bus.ack, head.isErr ? 2'b00 : head.grant);
          checkOutput("err", bus.err, head.isErr ? head.grant : 2'b00);
          checkOutput("rdata", bus.rdata, head.rdata);
          checkOutput("busy cycles", 96'(busyCnt), 96'(head.busyCycles));
          checkOutput("owner in done", bus.owner, head.grant);
        end
        busyCnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    int cyc;
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    bus.wea = 2'b00;
    setCmd(0, 1'b0, 4'h0, 32'h0, 32'h0, 3'h0);
    setCmd(1, 1'b0, 4'h0, 32'h0, 32'h0, 3'h0);
    #12;
    checkOutput("reset handshake outputs", {bus.ack, bus.err, bus.owner, bus.mem_wea, bus.mem_rea}, '0);
    checkOutput("reset mem outputs", {bus.mem_en, bus.storecntrl, bus.mem_addr, bus.mem_din}, '0);
    checkOutput("reset rdata", bus.rdata, '0);
    @(negedge clk);
    Rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] contention: both writes held, expecting 0,1,0,1");
    setCmd(0, 1'b1, 4'hF, 32'h200, 32'h11111111, 3'd2);
    setCmd(1, 1'b1, 4'h3, 32'h300, 32'h22222222, 3'd1);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) expQ.push_back(mkExp(2'b01, 1'b0, 1'b1, 4'hF, 32'h200, 32'h11111111, 3'd2, 32'h0, 1));
      else            expQ.push_back(mkExp(2'b10, 1'b0, 1'b1, 4'h3, 32'h300, 32'h22222222, 3'd1, 32'h0, 1));
    end
    applyStimulus(2'b11, 1'b0, 1'b0, 32'hBAD0BAD0);
    waitCompletions(4, 40);
    applyStimulus(2'b00, 1'b0, 1'b0, 32'hBAD0BAD0);
    repeat (2) @(negedge clk);

    $display("[TB] single read from requester 0");
    setCmd(0, 1'b0, 4'hF, 32'h100, 32'h0, 3'd2);
    expQ.push_back(mkExp(2'b01, 1'b0, 1'b0, 4'hF, 32'h100, 32'h0, 3'd2, 32'hDEADBEEF, 1));
    applyStimulus(2'b01, 1'b0, 1'b0, 32'hDEADBEEF);
    waitCompletions(1, 10);
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);

    $display("[TB] lock: only requester 1 may win");
    setCmd(0, 1'b0, 4'hF, 32'h400, 32'h0, 3'd2);
    setCmd(1, 1'b0, 4'h3, 32'h500, 32'h0, 3'd1);
    expQ.push_back(mkExp(2'b10, 1'b0, 1'b0, 4'h3, 32'h500, 32'h0, 3'd1, 32'hCAFEF00D, 1));
    applyStimulus(2'b11, 1'b1, 1'b0, 32'hCAFEF00D);
    waitCompletions(1, 10);
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h12345678);
    repeat (5) @(negedge clk);
    checkOutput("owner while locked out", bus.owner, 2'b00);
    expQ.push_back(mkExp(2'b01, 1'b0, 1'b0, 4'hF, 32'h400, 32'h0, 3'd2, 32'h12345678, 1));
    applyStimulus(2'b01, 1'b0, 1'b0, 32'h12345678);
    waitCompletions(1, 10);
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);

    $display("[TB] hold stretch: 5 hold cycles, 6 busy cycles, then ack");
    setCmd(0, 1'b1, 4'hC, 32'h600, 32'hA5A5A5A5, 3'd0);
    expQ.push_back(mkExp(2'b01, 1'b0, 1'b1, 4'hC, 32'h600, 32'hA5A5A5A5, 3'd0, 32'h12345678, 6));
    applyStimulus(2'b01, 1'b0, 1'b1, 32'h0BADF00D);
    cnt = 0;
    cyc = 0;
    while (cnt < 6 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_wea | bus.mem_rea) cnt++;
    end
    checkOutput("hold stretch busy count", 96'(cnt), 96'(6));
    bus.mem_hold = 1'b0;
    waitCompletions(1, 5);
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);

    $display("[TB] timeout: hold stuck high on a requester 1 read");
    setCmd(1, 1'b0, 4'hF, 32'h700, 32'h0, 3'd4);
    expQ.push_back(mkExp(2'b10, 1'b1, 1'b0, 4'hF, 32'h700, 32'h0, 3'd4, 32'h12345678, 6));
    applyStimulus(2'b10, 1'b0, 1'b1, 32'hFFFFFFFF);
    waitCompletions(1, 15);
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);

    $display("[TB] async reset while busy");
    setCmd(1, 1'b0, 4'hF, 32'h900, 32'h0, 3'd2);
    expQ.push_back(mkExp(2'b10, 1'b0, 1'b0, 4'hF, 32'h900, 32'h0, 3'd2, 32'h0, 99));
    applyStimulus(2'b10, 1'b0, 1'b1, 32'h77777777);
    repeat (3) @(negedge clk);
    #2;
    expQ.delete();
    busyCnt = 0;
    Rst_n = 1'b0;
    #1;
    checkOutput("async reset handshake outputs", {bus.ack, bus.err, bus.owner, bus.mem_wea, bus.mem_rea}, '0);
    checkOutput("async reset mem outputs", {bus.mem_en, bus.storecntrl, bus.mem_addr, bus.mem_din}, '0);
    checkOutput("async reset rdata", bus.rdata, '0);
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    Rst_n = 1'b1;
    @(negedge clk);
    setCmd(0, 1'b0, 4'hF, 32'h800, 32'h0, 3'd2);
    setCmd(1, 1'b0, 4'h1, 32'h880, 32'h0, 3'd0);
    expQ.push_back(mkExp(2'b01, 1'b0, 1'b0, 4'hF, 32'h800, 32'h0, 3'd2, 32'h5555AAAA, 1));
    applyStimulus(2'b11, 1'b0, 1'b0, 32'h5555AAAA);
    waitCompletions(1, 10);
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);

    checkOutput("scoreboard drained", 96'(expQ.size()), 96'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
